// File: rtl/uart_ctr_monitor.sv
// Taps APB writes to UART0 off the 128-bit uart_ctr_bus, recovers THR characters and
// streams them to the harness through a FIFO, with overflow and newline statistics.
module uart_ctr_monitor #(
  parameter int DEPTH     = 16,
  parameter int LANE_MODE = 0,
  parameter int CNT_W     = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [127:0]     uart_ctr_bus,
  input  logic             mon_en,
  input  logic             flush,
  output logic             char_valid,
  output logic [7:0]       char_data,
  input  logic             char_ready,
  output logic             overflow,
  output logic [15:0]      drop_cnt,
  output logic [CNT_W-1:0] char_total,
  output logic [CNT_W-1:0] line_cnt,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] OFS_THR = 4'd0;
  localparam logic [3:0] OFS_LCR = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_nxt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Bus field extraction
  logic [31:0] pwdata;
  logic [3:0]  paddr;
  logic        pwrite;
  logic        penable;
  logic        unused_bus_bits;

  assign pwdata          = uart_ctr_bus[127:96];
  assign paddr           = uart_ctr_bus[67:64];
  assign pwrite          = uart_ctr_bus[32];
  assign penable         = uart_ctr_bus[0];
  assign unused_bus_bits = ^{uart_ctr_bus[95:68], uart_ctr_bus[63:33], uart_ctr_bus[31:1]};

  logic       wr;
  logic       wr_q;
  logic       evt;
  logic [7:0] sel_byte;
  logic       dlab;
  logic       thr_wr;
  logic       lcr_wr;

  assign wr       = penable & pwrite;
  assign evt      = wr & ~wr_q & mon_en;
  assign sel_byte = (LANE_MODE != 0) ? pwdata[{paddr[1:0], 3'b000} +: 8] : pwdata[7:0];
  assign thr_wr   = evt & (paddr == OFS_THR) & ~dlab;
  assign lcr_wr   = evt & (paddr == OFS_LCR);

  // FIFO storage and pointer bookkeeping
  logic [7:0]  mem [DEPTH];
  logic [AW:0] head;
  logic [AW:0] tail;
  logic        empty;
  logic        full;
  logic        pop;
  logic        flush_now;
  logic        room;
  logic        push_ok;
  logic        push_drop;

  assign empty     = (head == tail);
  assign full      = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
  assign char_valid = (state == IDLE) & ~empty;
  assign char_data  = char_valid ? mem[head[AW-1:0]] : 8'h00;
  assign pop       = char_valid & char_ready;
  assign flush_now = (state == IDLE) & flush;
  // A flush this cycle empties the FIFO, so a concurrent push always has room and survives it.
  assign room      = ~full | pop | flush_now;
  assign push_ok   = thr_wr & room;
  assign push_drop = thr_wr & ~room;
  assign busy      = (state == FLUSH);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      dlab       <= 1'b0;
      head       <= '0;
      tail       <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      char_total <= '0;
      line_cnt   <= '0;
    end else begin
      state <= state_nxt;
      wr_q  <= wr;
      if (lcr_wr) dlab <= sel_byte[7];

      if (flush_now)   head <= tail;
      else if (pop)    head <= head + {{AW{1'b0}}, 1'b1};
      if (push_ok)     tail <= tail + {{AW{1'b0}}, 1'b1};

      if (push_ok) begin
        char_total <= wrap_inc(char_total);
        if (sel_byte == 8'h0A) line_cnt <= wrap_inc(line_cnt);
      end
      if (push_drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

  // Character storage carries no reset; validity comes from the pointers.
  always_ff @(posedge aclk) begin
    if (push_ok) mem[tail[AW-1:0]] <= sel_byte;
  end

endmodule

// File: tb/tb_uart_ctr_monitor.sv
// Bench for uart_ctr_monitor: directed vector table, hand sequences for FIFO corners,
// and a randomized run against a queue-based reference model.
module tb_uart_ctr_monitor;

  localparam int DEPTH = 16;
  localparam int LANE  = 0;
  localparam int CNT_W = 32;

  logic             clk;
  logic             areset;
  logic [127:0]     bus;
  logic             mon_en;
  logic             flush;
  logic             char_valid;
  logic [7:0]       char_data;
  logic             char_ready;
  logic             overflow;
  logic [15:0]      drop_cnt;
  logic [CNT_W-1:0] char_total;
  logic [CNT_W-1:0] line_cnt;
  logic             busy;

  uart_ctr_monitor #(.DEPTH(DEPTH), .LANE_MODE(LANE), .CNT_W(CNT_W)) dut (
    .aclk(clk), .areset(areset), .uart_ctr_bus(bus), .mon_en(mon_en), .flush(flush),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .overflow(overflow), .drop_cnt(drop_cnt), .char_total(char_total),
    .line_cnt(line_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  q[$];
  logic        m_dlab, m_prev, m_flush, m_ovf;
  int          m_drop;
  logic [31:0] m_total, m_lines;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] a, input logic [31:0] d, input logic pen, pwr,
                            input logic en, fl, rdy, rst);
    logic wr, evt, nf;
    logic [7:0] b;
    if (rst) begin
      q.delete();
      m_dlab = 0; m_prev = 0; m_flush = 0; m_ovf = 0; m_drop = 0; m_total = 0; m_lines = 0;
      return;
    end
    wr  = pen & pwr;
    evt = wr && !m_prev && en;
    if (!m_flush && q.size() > 0 && rdy) void'(q.pop_front());
    nf = !m_flush && fl;
    if (nf) q.delete();
    if (evt) begin
      b = (LANE != 0) ? 8'(d >> (8 * a[1:0])) : d[7:0];
      if (a == 4'd3) m_dlab = b[7];
      else if (a == 4'd0 && !m_dlab) begin
        if (q.size() < DEPTH) begin
          q.push_back(b);
          m_total++;
          if (b == 8'h0A) m_lines++;
        end else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
    m_prev  = wr;
    m_flush = nf;
  endtask

  task automatic compare_model();
    logic ev;
    logic [7:0] ed;
    ev = !m_flush && q.size() > 0;
    ed = ev ? q[0] : 8'h00;
    chk("m_valid", 64'(char_valid), 64'(ev));
    chk("m_data", 64'(char_data), 64'(ed));
    chk("m_overflow", 64'(overflow), 64'(m_ovf));
    chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("m_char_total", 64'(char_total), 64'(m_total));
    chk("m_line_cnt", 64'(line_cnt), 64'(m_lines));
    chk("m_busy", 64'(busy), 64'(m_flush));
  endtask

  // One clock cycle: drive, step the model, clock, then compare after the edge.
  task automatic cyc(input logic [3:0] a, input logic [31:0] d, input logic pen, pwr,
                     input logic en, fl, rdy, rst);
    bus        = '0;
    bus[127:96] = d;
    bus[67:64] = a;
    bus[32]    = pwr;
    bus[0]     = pen;
    mon_en     = en;
    flush      = fl;
    char_ready = rdy;
    areset     = rst;
    model_step(a, d, pen, pwr, en, fl, rdy, rst);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle(input logic rdy);
    cyc(4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 1'b0);
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic rdy);
    cyc(a, d, 1'b1, 1'b1, 1'b1, 1'b0, rdy, 1'b0);
    idle(rdy);
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic        pen, pwr, en, fl, rdy;
    logic        e_valid;
    logic [7:0]  e_data;
    logic [31:0] e_total, e_lines;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{4'd0, 32'h41, 1, 1, 1, 0, 1, 1, 8'h41, 1, 0};
    tbl[1]  = '{4'd0, 32'h00, 0, 0, 1, 0, 1, 0, 8'h00, 1, 0};
    tbl[2]  = '{4'd3, 32'h80, 1, 1, 1, 0, 1, 0, 8'h00, 1, 0};
    tbl[3]  = '{4'd0, 32'h00, 0, 0, 1, 0, 1, 0, 8'h00, 1, 0};
    tbl[4]  = '{4'd0, 32'h55, 1, 1, 1, 0, 1, 0, 8'h00, 1, 0};
    tbl[5]  = '{4'd0, 32'h00, 0, 0, 1, 0, 1, 0, 8'h00, 1, 0};
    tbl[6]  = '{4'd3, 32'h03, 1, 1, 1, 0, 1, 0, 8'h00, 1, 0};
    tbl[7]  = '{4'd0, 32'h00, 0, 0, 1, 0, 1, 0, 8'h00, 1, 0};
    tbl[8]  = '{4'd0, 32'h0A, 1, 1, 1, 0, 0, 1, 8'h0A, 2, 1};
    tbl[9]  = '{4'd0, 32'h00, 0, 0, 1, 0, 0, 1, 8'h0A, 2, 1};
    tbl[10] = '{4'd0, 32'h00, 0, 0, 1, 0, 1, 0, 8'h00, 2, 1};
    tbl[11] = '{4'd0, 32'h33, 1, 1, 1, 0, 0, 1, 8'h33, 3, 1};
    tbl[12] = '{4'd0, 32'h33, 1, 1, 1, 0, 0, 1, 8'h33, 3, 1};
    tbl[13] = '{4'd0, 32'h33, 1, 1, 1, 0, 0, 1, 8'h33, 3, 1};
    tbl[14] = '{4'd0, 32'h00, 0, 0, 1, 0, 1, 0, 8'h00, 3, 1};
    tbl[15] = '{4'd0, 32'h77, 1, 1, 0, 0, 1, 0, 8'h00, 3, 1};
    tbl[16] = '{4'd0, 32'h00, 0, 0, 1, 0, 1, 0, 8'h00, 3, 1};
    tbl[17] = '{4'd0, 32'h66, 1, 0, 1, 0, 1, 0, 8'h00, 3, 1};
    tbl[18] = '{4'd0, 32'h00, 0, 0, 1, 0, 1, 0, 8'h00, 3, 1};

    bus = '0; mon_en = 1; flush = 0; char_ready = 0; areset = 1;

    // Reset state
    cyc(4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 64'(char_valid), 64'd0);
    chk("rst_total", 64'(char_total), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].a, tbl[i].d, tbl[i].pen, tbl[i].pwr, tbl[i].en, tbl[i].fl, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 64'(char_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i), 64'(char_data), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_total", i), 64'(char_total), 64'(tbl[i].e_total));
      chk($sformatf("tbl%0d_lines", i), 64'(line_cnt), 64'(tbl[i].e_lines));
    end

    // Overflow: DEPTH+3 pushes with the consumer stalled
    cyc(4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 3; i++) write(4'd0, 32'(8'h60 + i), 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd3);
    chk("ovf_total", 64'(char_total), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_drain", 64'(char_data), 64'(8'h60 + i));
      idle(1'b1);
    end
    chk("ovf_empty", 64'(char_valid), 64'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) write(4'd0, 32'(8'hA0 + i), 1'b0);
    chk("full_head", 64'(char_data), 64'hA0);
    cyc(4'd0, 32'h99, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pp_drop", 64'(drop_cnt), 64'd3);
    chk("pp_head", 64'(char_data), 64'hA1);
    chk("pp_total", 64'(char_total), 64'(2 * DEPTH + 1));
    idle(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("pp_drain", 64'(char_data), (i < DEPTH - 1) ? 64'(8'hA1 + i) : 64'h99);
      idle(1'b1);
    end

    // Flush with a concurrent THR write, then reset mid-stream
    for (int i = 0; i < 5; i++) write(4'd0, 32'(8'h30 + i), 1'b0);
    cyc(4'd0, 32'h42, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fl_busy", 64'(busy), 64'd1);
    chk("fl_valid", 64'(char_valid), 64'd0);
    idle(1'b0);
    chk("fl_busy_end", 64'(busy), 64'd0);
    chk("fl_head", 64'(char_data), 64'h42);
    idle(1'b1);
    chk("fl_empty", 64'(char_valid), 64'd0);
    for (int i = 0; i < 3; i++) write(4'd0, 32'(8'h0A), 1'b0);
    cyc(4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ar_valid", 64'(char_valid), 64'd0);
    chk("ar_data", 64'(char_data), 64'd0);
    chk("ar_ovf", 64'(overflow), 64'd0);
    chk("ar_drop", 64'(drop_cnt), 64'd0);
    chk("ar_total", 64'(char_total), 64'd0);
    chk("ar_lines", 64'(line_cnt), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      logic [31:0] d;
      int sel;
      sel = $urandom_range(0, 9);
      a = (sel < 6) ? 4'd0 : (sel < 8) ? 4'd3 : 4'($urandom_range(0, 15));
      d = $urandom;
      if ($urandom_range(0, 3) != 0 && a == 4'd3) d[7] = 1'b0;
      if ($urandom_range(0, 4) == 0) d[7:0] = 8'h0A;
      cyc(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 499) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
